// File: rtl/riscv_types.sv
// Shared types for the M/W pipeline register bank: forward-select codes and
// the pipeline entry carried through the M and W registers.
package riscv_types;

  localparam int MW_XLEN = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic               rd_wr;
    logic [4:0]         rd_addr;
    logic               is_load;
    logic [MW_XLEN-1:0] data;
  } mw_entry_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register holding an mw_entry_t. A bubble loads an all-zero
// entry, which is also the reset value, so an empty slot never writes.
module pipe_stage_reg
  import riscv_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      bubble,
  input  mw_entry_t d,
  output mw_entry_t q
);

  // Capture the next entry, or an empty slot on reset/bubble
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mw_pipe_fwd.sv
// E/M and M/W pipeline registers of the RV32 core with the execute and decode
// forwarding muxes and the register-file write port.
// Optional feature: define MW_PERF_EN to build saturating stall/flush cycle
// counters; otherwise perf_stall_o/perf_flush_o are tied to zero.
module mw_pipe_fwd
  import riscv_types::*;
#(
  parameter int XLEN  = MW_XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             e_valid_i,
  input  logic             e_rd_wr_i,
  input  logic [4:0]       e_rd_addr_i,
  input  logic             e_is_load_i,
  input  logic [XLEN-1:0]  e_alu_res_i,
  input  logic [XLEN-1:0]  e_rs1_data_i,
  input  logic [XLEN-1:0]  e_rs2_data_i,
  input  logic [XLEN-1:0]  d_rs1_data_i,
  input  logic [XLEN-1:0]  d_rs2_data_i,
  input  logic [XLEN-1:0]  m_load_data_i,
  input  logic             stall_i,
  input  logic             flush_em_i,
  input  logic [1:0]       fwd_rs1_i,
  input  logic [1:0]       fwd_rs2_i,
  input  logic [1:0]       fwd_dec_i,
  output logic             rd_wr_M,
  output logic             is_load_M,
  output logic [4:0]       rd_addr_M,
  output logic             rd_wr_W,
  output logic [4:0]       rd_addr_W,
  output logic [XLEN-1:0]  m_alu_res_o,
  output logic [XLEN-1:0]  e_op1_o,
  output logic [XLEN-1:0]  e_op2_o,
  output logic [XLEN-1:0]  d_rs1_o,
  output logic [XLEN-1:0]  d_rs2_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o
);

  mw_entry_t e_entry;
  mw_entry_t m_entry;
  mw_entry_t w_next;
  mw_entry_t w_entry;
  logic      m_bubble;
  logic      w_unused;

  assign m_bubble = stall_i | flush_em_i;

  // Pack the execute-stage fields into the entry headed for M
  always_comb begin
    e_entry         = '0;
    e_entry.valid   = e_valid_i;
    e_entry.rd_wr   = e_rd_wr_i;
    e_entry.rd_addr = e_rd_addr_i;
    e_entry.is_load = e_is_load_i;
    e_entry.data    = e_alu_res_i;
  end

  // Resolve M data for W: loads take the memory read data
  always_comb begin
    w_next      = m_entry;
    w_next.data = m_entry.is_load ? m_load_data_i : m_entry.data;
  end

  pipe_stage_reg u_m_reg (
    .clk    (clk_i),
    .rst    (rst_i),
    .bubble (m_bubble),
    .d      (e_entry),
    .q      (m_entry)
  );

  pipe_stage_reg u_w_reg (
    .clk    (clk_i),
    .rst    (rst_i),
    .bubble (1'b0),
    .d      (w_next),
    .q      (w_entry)
  );

  assign w_unused    = w_entry.is_load;

  assign rd_wr_M     = m_entry.valid & m_entry.rd_wr;
  assign is_load_M   = m_entry.valid & m_entry.is_load;
  assign rd_addr_M   = m_entry.rd_addr;
  assign m_alu_res_o = m_entry.data;

  assign rd_wr_W     = w_entry.valid & w_entry.rd_wr;
  assign rd_addr_W   = w_entry.rd_addr;

  assign rf_we_o     = rd_wr_W & (w_entry.rd_addr != 5'd0);
  assign rf_waddr_o  = w_entry.rd_addr;
  assign rf_wdata_o  = w_entry.data;

  // Execute operand forwarding from M result or W data
  always_comb begin
    e_op1_o = e_rs1_data_i;
    e_op2_o = e_rs2_data_i;
    case (fwd_sel_e'(fwd_rs1_i))
      FWD_MEM: e_op1_o = m_entry.data;
      FWD_WB:  e_op1_o = w_entry.data;
      default: e_op1_o = e_rs1_data_i;
    endcase
    case (fwd_sel_e'(fwd_rs2_i))
      FWD_MEM: e_op2_o = m_entry.data;
      FWD_WB:  e_op2_o = w_entry.data;
      default: e_op2_o = e_rs2_data_i;
    endcase
  end

  // Decode forwarding trusts the select code; no x0 or validity check here
  always_comb begin
    d_rs1_o = d_rs1_data_i;
    d_rs2_o = d_rs2_data_i;
    case (fwd_dec_i)
      2'b01:   d_rs1_o = w_entry.data;
      2'b10:   d_rs2_o = w_entry.data;
      default: ;
    endcase
  end

`ifdef MW_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counts of stall and flush cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_i && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_em_i && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign perf_stall_o = stall_cnt;
  assign perf_flush_o = flush_cnt;
`else
  assign perf_stall_o = '0;
  assign perf_flush_o = '0;
`endif

endmodule
